// File: rtl/simon_autoplayer_if.sv
// Game-side signal bundle between the Simon core and its autoplayer.
// master drives LEDs/phases/enable; slave (the autoplayer) drives buttons and status.
interface simon_autoplayer_if #(
    parameter int LEN_W = 6
);
    logic             ena;
    logic [3:0]       led_in;
    logic             show_phase;
    logic             input_phase;
    logic [3:0]       btn_out;
    logic             busy;
    logic [LEN_W-1:0] seq_len;
    logic             overflow;
    logic             err;

    modport master (
        output ena, led_in, show_phase, input_phase,
        input  btn_out, busy, seq_len, overflow, err
    );

    modport slave (
        input  ena, led_in, show_phase, input_phase,
        output btn_out, busy, seq_len, overflow, err
    );
endinterface

// File: rtl/simon_autoplayer.sv
// Simon self-play driver: records the LED colour sequence, replays it as timed one-hot presses.
// First press 2 clocks after input_phase rises; no backpressure, ena=0 freezes everything.
module simon_autoplayer #(
    parameter int MAX_LEN      = 32,
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int LEN_W        = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    simon_autoplayer_if.slave bus
);
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_WAIT_INPUT, S_PRESS, S_GAP, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_led_q, r_led_prev;
    logic             r_show_q, r_show_prev, r_input_q;
    logic [LEN_W-1:0] r_seq_len, r_idx;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_buf [MAX_LEN];

    logic             w_onehot, w_invalid, w_cap_edge, w_show_rise, w_show_fall, w_full;
    logic [1:0]       w_code;
    logic             w_clear, w_store, w_cnt_clr, w_idx_clr, w_idx_inc;
    logic [AW-1:0]    w_wr_ptr, w_rd_ptr;

    assign w_onehot    = (r_led_q != 4'd0) && ((r_led_q & (r_led_q - 4'd1)) == 4'd0);
    assign w_invalid   = (r_led_q != 4'd0) && !w_onehot;
    // r_led_prev holds only valid colours, so a garbled sample looks like dark
    assign w_cap_edge  = w_onehot && (r_led_q != r_led_prev);
    assign w_show_rise = r_show_q && !r_show_prev;
    assign w_show_fall = !r_show_q && r_show_prev;
    assign w_full      = (r_seq_len == LEN_W'(MAX_LEN));
    assign w_wr_ptr    = r_seq_len[AW-1:0];
    assign w_rd_ptr    = r_idx[AW-1:0];

    always_comb begin
        case (r_led_q)
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_store     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_show_rise) begin
                    w_state_nxt = S_CAPTURE;
                    w_clear     = 1'b1;
                end
            end
            S_CAPTURE: begin
                w_store = w_cap_edge;
                if (w_show_fall) w_state_nxt = S_WAIT_INPUT;
            end
            S_WAIT_INPUT, S_DONE: begin
                if (w_show_rise) begin
                    w_state_nxt = S_CAPTURE;
                    w_clear     = 1'b1;
                end else if (r_state == S_DONE) begin
                    if (!r_input_q) w_state_nxt = S_IDLE;
                end else if (r_input_q) begin
                    w_state_nxt = (r_seq_len == '0) ? S_DONE : S_PRESS;
                    w_idx_clr   = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_PRESS: begin
                if (!r_input_q) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(PRESS_CYCLES - 1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_GAP: begin
                if (!r_input_q) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_idx_inc   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ((r_idx + LEN_W'(1)) == r_seq_len) ? S_DONE : S_PRESS;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else if (bus.ena) r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_q     <= 4'd0;
            r_led_prev  <= 4'd0;
            r_show_q    <= 1'b0;
            r_show_prev <= 1'b0;
            r_input_q   <= 1'b0;
            r_seq_len   <= '0;
            r_overflow  <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
        end else if (bus.ena) begin
            r_led_q     <= bus.led_in;
            r_led_prev  <= w_onehot ? r_led_q : 4'd0;
            r_show_q    <= bus.show_phase;
            r_show_prev <= r_show_q;
            r_input_q   <= bus.input_phase;
            if (w_clear) begin
                r_seq_len  <= '0;
                r_overflow <= 1'b0;
            end else if (w_store) begin
                if (w_full) r_overflow <= 1'b1;
                else        r_seq_len  <= r_seq_len + LEN_W'(1);
            end
            if (w_idx_clr)      r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + LEN_W'(1);
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.ena && w_store && !w_full) r_buf[w_wr_ptr] <= w_code;
    end

    // Output is gated by the registered input phase so an abort releases the button at once
    always_comb begin
        bus.btn_out  = 4'd0;
        if (bus.ena && r_state == S_PRESS && r_input_q) bus.btn_out = 4'b0001 << r_buf[w_rd_ptr];
        bus.err      = bus.ena && (r_state == S_CAPTURE) && w_invalid;
        bus.busy     = (r_state == S_CAPTURE) || (r_state == S_PRESS) || (r_state == S_GAP);
        bus.seq_len  = r_seq_len;
        bus.overflow = r_overflow;
    end
endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer: table vectors, random LED sequences vs a sequence-level model, corner cases.
`timescale 1ns/1ps
module tb_simon_autoplayer;
    localparam int MAX_LEN = 32;
    localparam int P       = 4;
    localparam int G       = 4;
    localparam int LEN_W   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simon_autoplayer_if #(.LEN_W(LEN_W)) bus ();

    simon_autoplayer #(
        .MAX_LEN(MAX_LEN), .PRESS_CYCLES(P), .GAP_CYCLES(G), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] stim[$];
    logic [1:0] mdl_seq[$];
    bit         mdl_ovf;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [3:0] led[6];
        int         hold[6];
        int         n;
        int         exp_len;
        logic [1:0] exp_c[6];
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Play stim[] on the LEDs inside a show window; model derives the stored colours.
    task automatic run_show();
        logic [3:0] prev;
        prev = 4'd0;
        mdl_seq.delete();
        mdl_ovf = 1'b0;
        bus.show_phase = 1'b1;
        bus.led_in = 4'd0;
        tick(); tick(); tick();
        chk("capture_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < stim.size(); i++) begin
            bus.led_in = stim[i];
            tick();
            chk("err", 32'(bus.err), 32'(stim[i] != 4'd0 && $countones(stim[i]) != 1));
            if ($countones(stim[i]) == 1) begin
                if (stim[i] != prev) begin
                    if (mdl_seq.size() == MAX_LEN) mdl_ovf = 1'b1;
                    else mdl_seq.push_back(2'($clog2(stim[i])));
                end
                prev = stim[i];
            end else begin
                prev = 4'd0;
            end
        end
        bus.led_in = 4'd0;
        bus.show_phase = 1'b0;
        tick(); tick(); tick();
        chk("seq_len", 32'(bus.seq_len), 32'(mdl_seq.size()));
        chk("overflow", 32'(bus.overflow), 32'(mdl_ovf));
    endtask

    // Raise input_phase and compare the button trace with exp_q.
    task automatic replay(input int freeze_at, input int abort_at);
        int k;
        logic [3:0] exp_btn;
        k = 0;
        bus.input_phase = 1'b1;
        tick();
        chk("latency", 32'(bus.btn_out), 32'd0);
        for (int c = 0; c < exp_q.size(); c++) begin
            for (int j = 0; j < P + G; j++) begin
                tick();
                exp_btn = (j < P) ? (4'b0001 << exp_q[c]) : 4'd0;
                chk($sformatf("btn c%0d j%0d", c, j), 32'(bus.btn_out), 32'(exp_btn));
                if (j == 0) chk("replay_busy", 32'(bus.busy), 32'd1);
                if (k == freeze_at) begin
                    bus.ena = 1'b0;
                    for (int f = 0; f < 10; f++) begin
                        tick();
                        chk("freeze_btn", 32'(bus.btn_out), 32'd0);
                    end
                    chk("freeze_busy", 32'(bus.busy), 32'd1);
                    bus.ena = 1'b1;
                end
                if (k == abort_at) begin
                    bus.input_phase = 1'b0;
                    tick();
                    chk("abort_btn", 32'(bus.btn_out), 32'd0);
                    tick();
                    chk("abort_idle", 32'(bus.busy), 32'd0);
                    chk("abort_len", 32'(bus.seq_len), 32'(exp_q.size()));
                    return;
                end
                k++;
            end
        end
        tick();
        chk("done_btn", 32'(bus.btn_out), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_len", 32'(bus.seq_len), 32'(exp_q.size()));
        bus.input_phase = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [3:0] v;
        int n_el, hold, r;

        tbl[0].led = '{4'h1, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
        tbl[0].hold = '{3, 3, 3, 3, 3, 3};
        tbl[0].n = 6; tbl[0].exp_len = 3; tbl[0].exp_c = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        tbl[1].led = '{4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1].hold = '{10, 3, 2, 1, 1, 1};
        tbl[1].n = 3; tbl[1].exp_len = 2; tbl[1].exp_c = '{2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        tbl[2].led = '{4'h1, 4'h0, 4'h6, 4'h0, 4'h4, 4'h0};
        tbl[2].hold = '{2, 1, 1, 1, 2, 1};
        tbl[2].n = 6; tbl[2].exp_len = 2; tbl[2].exp_c = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        tbl[3].led = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
        tbl[3].hold = '{1, 1, 1, 1, 2, 1};
        tbl[3].n = 5; tbl[3].exp_len = 4; tbl[3].exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        tbl[4].led = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[4].hold = '{1, 1, 1, 1, 1, 1};
        tbl[4].n = 0; tbl[4].exp_len = 0; tbl[4].exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

        bus.ena = 1'b1;
        bus.led_in = 4'd0;
        bus.show_phase = 1'b0;
        bus.input_phase = 1'b0;
        #12;
        chk("rst_btn", 32'(bus.btn_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_len", 32'(bus.seq_len), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) begin
            stim.delete();
            for (int e = 0; e < tbl[t].n; e++)
                for (int h = 0; h < tbl[t].hold[e]; h++) stim.push_back(tbl[t].led[e]);
            run_show();
            chk($sformatf("vec%0d_len", t), 32'(bus.seq_len), 32'(tbl[t].exp_len));
            exp_q.delete();
            for (int e = 0; e < tbl[t].exp_len; e++) exp_q.push_back(tbl[t].exp_c[e]);
            replay(-1, -1);
        end

        // Overflow: 34 colours, only the first 32 survive
        stim.delete();
        for (int i = 0; i < 34; i++) begin
            stim.push_back(4'b0001 << $urandom_range(0, 3));
            stim.push_back(4'd0);
        end
        run_show();
        chk("ovf_len", 32'(bus.seq_len), 32'd32);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        exp_q = mdl_seq;
        replay(-1, -1);

        for (int round = 0; round < 10; round++) begin
            stim.delete();
            n_el = $urandom_range(0, 12);
            for (int e = 0; e < n_el; e++) begin
                r = $urandom_range(0, 9);
                hold = $urandom_range(1, 3);
                if (r < 6) v = 4'b0001 << $urandom_range(0, 3);
                else if (r < 8) v = 4'd0;
                else begin
                    do v = 4'($urandom_range(3, 15)); while ($countones(v) < 2);
                end
                for (int h = 0; h < hold; h++) stim.push_back(v);
            end
            run_show();
            exp_q = mdl_seq;
            replay(-1, -1);
        end

        // Colour arriving in the same cycle as show_phase falling is kept
        bus.show_phase = 1'b1;
        tick(); tick(); tick();
        bus.led_in = 4'h1; tick();
        bus.led_in = 4'h0; tick();
        bus.led_in = 4'h4; bus.show_phase = 1'b0; tick();
        bus.led_in = 4'h0; tick(); tick();
        chk("fall_cap_len", 32'(bus.seq_len), 32'd2);
        exp_q = '{2'd0, 2'd2};
        replay(-1, -1);

        // show_phase rise wins over input_phase in WAIT_INPUT
        stim = '{4'h1, 4'h0};
        run_show();
        bus.show_phase = 1'b1; bus.input_phase = 1'b1;
        tick(); tick();
        chk("race_busy", 32'(bus.busy), 32'd1);
        chk("race_btn", 32'(bus.btn_out), 32'd0);
        chk("race_len", 32'(bus.seq_len), 32'd0);
        bus.led_in = 4'h4; tick();
        bus.led_in = 4'h0; bus.input_phase = 1'b0; tick();
        bus.show_phase = 1'b0; tick(); tick(); tick();
        chk("race_len2", 32'(bus.seq_len), 32'd1);
        exp_q = '{2'd2};
        replay(-1, -1);

        // Abort during the second press
        stim = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
        run_show();
        exp_q = mdl_seq;
        replay(-1, P + G + 1);

        // ena low for 10 cycles mid-gap
        stim = '{4'h2, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0};
        run_show();
        exp_q = mdl_seq;
        replay(P + 1, -1);

        // Reset mid-press
        stim = '{4'h8, 4'h0, 4'h1, 4'h0};
        run_show();
        bus.input_phase = 1'b1;
        tick(); tick();
        chk("pre_rst_btn", 32'(bus.btn_out), 32'h8);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_btn", 32'(bus.btn_out), 32'd0);
        chk("mid_rst_len", 32'(bus.seq_len), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        bus.input_phase = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
